tt_um_hoene_protocol_frame_deserializer: RTL and testbench

//  Parametrised serial-to-parallel frame receiver for the smart-LED daisy chain.

---
 rtl/tt_um_hoene_protocol_frame_deserializer.sv | 136 +++++++++++++
 tb/tb_tt_um_hoene_protocol_frame_deserializer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_hoene_protocol_frame_deserializer.sv
// Serial-to-parallel frame receiver for the smart-LED daisy chain: collects the first
// WIDTH bits of a frame, checks count/parity on store and forwards surplus bits downstream.
module tt_um_hoene_protocol_frame_deserializer #(
    parameter int WIDTH      = 32,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_data,
    input  logic             in_clk,
    input  logic             store,
    input  logic             clear,
    output logic [WIDTH-1:0] output_data,
    output logic             out_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             fwd_data,
    output logic             fwd_clk,
    output logic             fwd_store
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_FORWARD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             fdata_q, fdata_d;
    logic             fclk_q, fclk_d;
    logic             fstore_q, fstore_d;

    logic [WIDTH-1:0] shift_in;
    logic             parity_ok;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shift_in = {shift_q[WIDTH-2:0], in_data};
        end else begin : g_lsb_first
            assign shift_in = {in_data, shift_q[WIDTH-1:1]};
        end
    endgenerate

    assign parity_ok = (PARITY_EN == 0) || ((^shift_q) == 1'(PARITY_ODD));

    // clear outranks store, which outranks a bit strobe in the same cycle.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        count_d  = count_q;
        data_d   = data_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        fdata_d  = fdata_q;
        valid_d  = 1'b0;
        fclk_d   = 1'b0;
        fstore_d = 1'b0;
        if (clear) begin
            shift_d = '0;
            count_d = '0;
            state_d = ST_COLLECT;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
        end else if (store) begin
            fstore_d = 1'b1;
            if (count_q == FULL) begin
                ferr_d = 1'b0;
                if (parity_ok) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    perr_d  = 1'b0;
                end else begin
                    perr_d = 1'b1;
                end
            end else begin
                ferr_d = 1'b1;
                perr_d = 1'b0;
            end
            shift_d = '0;
            count_d = '0;
            state_d = ST_COLLECT;
        end else if (in_clk) begin
            if (state_q == ST_COLLECT) begin
                shift_d = shift_in;
                count_d = count_q + CW'(1);
                if (count_d == FULL) state_d = ST_FORWARD;
            end else begin
                fclk_d  = 1'b1;
                fdata_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_COLLECT;
            shift_q  <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            fdata_q  <= 1'b0;
            fclk_q   <= 1'b0;
            fstore_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            fdata_q  <= fdata_d;
            fclk_q   <= fclk_d;
            fstore_q <= fstore_d;
        end
    end

    assign output_data = data_q;
    assign out_valid   = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign fwd_data    = fdata_q;
    assign fwd_clk     = fclk_q;
    assign fwd_store   = fstore_q;

endmodule

// File: tb/tb_tt_um_hoene_protocol_frame_deserializer.sv
// Directed bench for the frame deserializer: a vector table for whole frames plus
// hand-written sequences for simultaneous strobes, async reset and clear.
module tb_tt_um_hoene_protocol_frame_deserializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_data = 1'b0;
    logic in_clk = 1'b0;
    logic store = 1'b0;
    logic clear = 1'b0;

    logic [31:0] o0_out, o1_out;
    logic o0_valid, o0_perr, o0_ferr, o0_fdata, o0_fclk, o0_fstore;
    logic o1_valid, o1_perr, o1_ferr, o1_fdata, o1_fclk, o1_fstore;

    int checks = 0;
    int fails  = 0;

    logic [0:0] exp_q[$];
    logic [0:0] obs_q[$];
    int fwd_cnt1 = 0;

    typedef struct {
        logic [63:0] din;
        int          nbits;
        logic [31:0] exp_out;
        logic        exp_valid;
        logic        exp_perr;
        logic        exp_ferr;
        int          exp_fwd;
    } vec_t;

    vec_t vecs[8];

    tt_um_hoene_protocol_frame_deserializer dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_clk(in_clk),
        .store(store), .clear(clear), .output_data(o0_out), .out_valid(o0_valid),
        .parity_err(o0_perr), .frame_err(o0_ferr), .fwd_data(o0_fdata),
        .fwd_clk(o0_fclk), .fwd_store(o0_fstore)
    );

    tt_um_hoene_protocol_frame_deserializer #(.MSB_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_clk(in_clk),
        .store(store), .clear(clear), .output_data(o1_out), .out_valid(o1_valid),
        .parity_err(o1_perr), .frame_err(o1_ferr), .fwd_data(o1_fdata),
        .fwd_clk(o1_fclk), .fwd_store(o1_fstore)
    );

    always #5 clk = ~clk;

    // Observed forwarded bits; the posedge sees the value held during the previous cycle.
    always @(posedge clk) begin
        if (rst_n && o0_fclk) obs_q.push_back(o0_fdata);
        if (rst_n && o1_fclk) fwd_cnt1 <= fwd_cnt1 + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        in_data = b;
        in_clk  = 1'b1;
        @(negedge clk);
        in_clk  = 1'b0;
    endtask

    task automatic pulse_store();
        store = 1'b1;
        @(negedge clk);
        store = 1'b0;
    endtask

    task automatic send_msb_pattern();
        send_bit(1'b1);
        for (int i = 0; i < 30; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    initial begin
        int base;
        int base1;
        logic [0:0] e;

        vecs[0] = '{64'h0000_0000_8000_0001, 32, 32'h8000_0001, 1'b1, 1'b0, 1'b0, 0};
        vecs[1] = '{64'h0000_0000_0000_0001, 32, 32'h8000_0001, 1'b0, 1'b1, 1'b0, 0};
        vecs[2] = '{64'h0000_0000_0000_000F, 32, 32'h0000_000F, 1'b1, 1'b0, 1'b0, 0};
        vecs[3] = '{64'h0000_00A5_8000_0001, 40, 32'h8000_0001, 1'b1, 1'b0, 1'b0, 8};
        vecs[4] = '{64'h0000_0000_1234_5678, 31, 32'h8000_0001, 1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{64'h0000_0000_0000_0000, 0,  32'h8000_0001, 1'b0, 1'b0, 1'b1, 0};
        vecs[6] = '{64'h0000_0000_0000_0007, 32, 32'h8000_0001, 1'b0, 1'b1, 1'b0, 0};
        vecs[7] = '{64'h0000_0001_0000_3C3C, 33, 32'h0000_3C3C, 1'b1, 1'b0, 1'b0, 1};

        repeat (3) @(negedge clk);
        check("reset output_data", {32'h0, o0_out}, 64'h0);
        check("reset flags", {o0_valid, o0_perr, o0_ferr, o0_fdata, o0_fclk, o0_fstore}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Whole-frame vectors, first bit lands in bit 0.
        for (int v = 0; v < 8; v++) begin
            base = obs_q.size();
            for (int i = 0; i < vecs[v].nbits; i++) begin
                if (i >= 32) exp_q.push_back(vecs[v].din[i]);
                send_bit(vecs[v].din[i]);
            end
            pulse_store();
            check($sformatf("v%0d output_data", v), {32'h0, o0_out}, {32'h0, vecs[v].exp_out});
            check($sformatf("v%0d out_valid", v), {63'h0, o0_valid}, {63'h0, vecs[v].exp_valid});
            check($sformatf("v%0d parity_err", v), {63'h0, o0_perr}, {63'h0, vecs[v].exp_perr});
            check($sformatf("v%0d frame_err", v), {63'h0, o0_ferr}, {63'h0, vecs[v].exp_ferr});
            check($sformatf("v%0d fwd_store", v), {63'h0, o0_fstore}, 64'h1);
            check($sformatf("v%0d fwd_clk count", v), 64'(obs_q.size() - base), 64'(vecs[v].exp_fwd));
            for (int k = base; k < obs_q.size(); k++) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                check($sformatf("v%0d fwd_data[%0d]", v, k - base), {63'h0, obs_q[k]}, {63'h0, e});
            end
            @(negedge clk);
            check($sformatf("v%0d pulses end", v), {62'h0, o0_valid, o0_fstore}, 64'h0);
        end
        check("fwd queue drained", 64'(exp_q.size()), 64'h0);

        // MSB-first instance: bits 1,0..0,1 give 0x80000001.
        send_msb_pattern();
        pulse_store();
        check("msb output_data", {32'h0, o1_out}, 64'h8000_0001);
        check("msb out_valid", {63'h0, o1_valid}, 64'h1);
        check("msb errs", {62'h0, o1_perr, o1_ferr}, 64'h0);

        // Strobe coinciding with store after 31 bits: bit discarded, short frame.
        base1 = fwd_cnt1;
        for (int i = 0; i < 31; i++) send_bit(1'b0);
        in_data = 1'b1;
        in_clk  = 1'b1;
        store   = 1'b1;
        @(negedge clk);
        in_clk  = 1'b0;
        store   = 1'b0;
        check("same-cycle frame_err", {62'h0, o1_ferr, o0_ferr}, 64'h3);
        check("same-cycle no valid", {62'h0, o1_valid, o0_valid}, 64'h0);
        check("same-cycle data held", {32'h0, o1_out}, 64'h8000_0001);
        check("same-cycle fwd_store", {63'h0, o1_fstore}, 64'h1);
        @(negedge clk);
        check("same-cycle no fwd_clk", 64'(fwd_cnt1 - base1), 64'h0);

        // Strobe coinciding with store on a full frame: not forwarded, frame still good.
        base1 = fwd_cnt1;
        send_msb_pattern();
        in_data = 1'b1;
        in_clk  = 1'b1;
        store   = 1'b1;
        @(negedge clk);
        in_clk  = 1'b0;
        store   = 1'b0;
        check("full same-cycle valid", {63'h0, o1_valid}, 64'h1);
        @(negedge clk);
        check("full same-cycle no fwd_clk", 64'(fwd_cnt1 - base1), 64'h0);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset output_data", {o1_out, o0_out}, 64'h0);
        check("async reset flags", {o0_valid, o0_perr, o0_ferr, o0_fdata, o0_fclk, o0_fstore}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = obs_q.size();
        for (int i = 0; i < 32; i++) send_bit(i < 4);
        pulse_store();
        check("post-reset frame", {31'h0, o0_valid, o0_out}, {31'h0, 1'b1, 32'h0000_000F});

        // Empty store raises frame_err; clear mid-frame drops it and the partial bits.
        @(negedge clk);
        pulse_store();
        check("empty store frame_err", {63'h0, o0_ferr}, 64'h1);
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear flags", {60'h0, o0_valid, o0_perr, o0_ferr, o0_fstore}, 64'h0);
        check("clear output held", {32'h0, o0_out}, 64'h0000_000F);
        for (int i = 0; i < 32; i++) send_bit((i == 0) || (i == 31));
        pulse_store();
        check("post-clear output_data", {32'h0, o0_out}, 64'h8000_0001);
        check("post-clear out_valid", {62'h0, o0_valid, o0_ferr}, 64'h2);
        check("post-reset no fwd_clk", 64'(obs_q.size() - base), 64'h0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
